// File: rtl/det_pkg.sv
// Shared types and constants for the Bareiss determinant engine.
package det_pkg;

    localparam int N_MAX_DEF  = 5;
    localparam int ELEM_W_DEF = 8;
    localparam int INT_W_DEF  = 48;
    localparam int OUT_W_DEF  = 8;

    localparam int OUT_MAX = 2 ** (OUT_W_DEF - 1) - 1;
    localparam int OUT_MIN = -(2 ** (OUT_W_DEF - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PIVOT,
        S_SWAP,
        S_UPD_MUL,
        S_UPD_DIV,
        S_FINISH,
        S_DONE
    } state_t;

    // LSB position of element (row, col) in the row-major bus, (0,0) in the MSBs.
    function automatic int elem_lsb(input int row, input int col, input int n_max, input int elem_w);
        return ((n_max * n_max - 1) - (row * n_max + col)) * elem_w;
    endfunction

endpackage

// File: rtl/seq_div_exact.sv
// Signed restoring divider, one quotient bit per cycle, fixed 2*INT_W+1 cycle latency.
module seq_div_exact #(
    parameter int INT_W = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [2*INT_W:0] dividend,
    input  logic signed [INT_W-1:0] divisor,
    output logic signed [INT_W-1:0] quotient,
    output logic                    rem_nz,
    output logic                    done
);

    localparam int DW = 2 * INT_W + 1;
    localparam int RW = INT_W + 1;
    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0]          dvd_sh;
    logic [DW-1:0]          dvd_mag;
    logic [INT_W-1:0]       quo_sh;
    logic [RW-1:0]          rem;
    logic [RW-1:0]          dsr_mag;
    logic [RW-1:0]          dsr_in_mag;
    logic signed [RW-1:0]   dsr_ext;
    logic [CW-1:0]          cnt;
    logic                   neg;
    logic [RW:0]            first;
    logic [RW:0]            step;

    // Returns {quotient bit, new partial remainder}.
    function automatic logic [RW:0] div_step(input logic [RW-1:0] r_in, input logic b,
                                             input logic [RW-1:0] d);
        logic [RW:0] t;
        t = {r_in, b};
        if (t >= {1'b0, d})
            return {1'b1, RW'(t - {1'b0, d})};
        return {1'b0, t[RW-1:0]};
    endfunction

    always_comb begin
        dvd_mag    = dividend[DW-1] ? DW'(-dividend) : DW'(dividend);
        dsr_ext    = RW'(divisor);
        dsr_in_mag = dsr_ext[RW-1] ? RW'(-dsr_ext) : RW'(dsr_ext);
        first      = div_step('0, dvd_mag[DW-1], dsr_in_mag);
        step       = div_step(rem, dvd_sh[DW-1], dsr_mag);
    end

    // The load cycle already resolves the first quotient bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_sh  <= '0;
            quo_sh  <= '0;
            rem     <= '0;
            dsr_mag <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= first[RW-1:0];
                quo_sh  <= INT_W'(first[RW]);
                dvd_sh  <= dvd_mag << 1;
                dsr_mag <= dsr_in_mag;
                neg     <= dividend[DW-1] ^ divisor[INT_W-1];
                cnt     <= CW'(DW - 1);
            end else if (cnt != '0) begin
                rem    <= step[RW-1:0];
                quo_sh <= {quo_sh[INT_W-2:0], step[RW]};
                dvd_sh <= dvd_sh << 1;
                cnt    <= cnt - CW'(1);
                done   <= (cnt == CW'(1));
            end
        end
    end

    assign quotient = neg ? -$signed(quo_sh) : $signed(quo_sh);
    assign rem_nz   = |rem;

endmodule

// File: rtl/det_bareiss_seq.sv
// Sequential determinant engine: fraction-free Bareiss elimination with row pivoting,
// one multiply step and one exact sequential division per updated minor.
module det_bareiss_seq
    import det_pkg::*;
#(
    parameter int N_MAX  = N_MAX_DEF,
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int INT_W  = INT_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2:0]                     size,
    input  logic [N_MAX*N_MAX*ELEM_W-1:0]  matrix,
    output logic                           busy,
    output logic                           done,
    output logic signed [OUT_W-1:0]        det,
    output logic signed [INT_W-1:0]        det_full,
    output logic                           ovf,
    output logic                           err,
    output state_t                         dbg_state
);

    // Request/response: start is a one-cycle request taken only in IDLE; busy rises the
    // next cycle; done is a one-cycle pulse and det/det_full/ovf/err hold until the next request.

    localparam int IW = $clog2(N_MAX);
    localparam int PW = 2 * INT_W + 1;
    localparam logic [IW-1:0] ONE = IW'(1);
    localparam logic signed [INT_W-1:0] SAT_MAX = {{(INT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] SAT_MIN = {{(INT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef logic [IW-1:0] idx_t;

    state_t                  state;
    logic signed [INT_W-1:0] m [N_MAX][N_MAX];
    logic signed [INT_W-1:0] prev;
    idx_t                    nm1, k, i, j, r;
    idx_t                    k1, k2;
    logic [2:0]              size_q;
    logic                    sign_neg;
    logic                    zero_res;
    logic                    size_ok;

    logic signed [PW-1:0]    a_ij, a_kk, a_ik, a_kj, prod;
    logic signed [INT_W-1:0] quo;
    logic signed [INT_W-1:0] fin_val;
    logic                    div_start;
    logic                    div_done;
    logic                    rem_nz_unused;

    always_comb begin
        k1      = k + ONE;
        k2      = k1 + ONE;
        size_ok = (size_q != 3'd0) && (int'(size_q) <= N_MAX);
        a_ij    = PW'(m[i][j]);
        a_kk    = PW'(m[k][k]);
        a_ik    = PW'(m[i][k]);
        a_kj    = PW'(m[k][j]);
        prod    = a_ij * a_kk - a_ik * a_kj;
        fin_val = m[nm1][nm1];
        if (sign_neg)
            fin_val = -m[nm1][nm1];
        if (zero_res)
            fin_val = '0;
    end

    assign div_start = (state == S_UPD_MUL);
    assign dbg_state = state;

    seq_div_exact #(
        .INT_W(INT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (prod),
        .divisor  (prev),
        .quotient (quo),
        .rem_nz   (rem_nz_unused),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            det      <= '0;
            det_full <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            prev     <= '0;
            nm1      <= '0;
            k        <= '0;
            i        <= '0;
            j        <= '0;
            r        <= '0;
            size_q   <= '0;
            sign_neg <= 1'b0;
            zero_res <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int rr = 0; rr < N_MAX; rr++)
                            for (int cc = 0; cc < N_MAX; cc++)
                                m[rr][cc] <= INT_W'($signed(matrix[elem_lsb(rr, cc, N_MAX, ELEM_W) +: ELEM_W]));
                        size_q   <= size;
                        nm1      <= IW'(size - 3'd1);
                        prev     <= INT_W'(1);
                        sign_neg <= 1'b0;
                        zero_res <= 1'b0;
                        k        <= '0;
                        err      <= 1'b0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                // A nonzero pivot is recognised here at no cost; PIVOT only runs the row scan.
                S_LOAD: begin
                    if (!size_ok) begin
                        err      <= 1'b1;
                        zero_res <= 1'b1;
                        state    <= S_FINISH;
                    end else if (nm1 == '0) begin
                        state <= S_FINISH;
                    end else if (m[0][0] != '0) begin
                        i     <= ONE;
                        j     <= ONE;
                        state <= S_UPD_MUL;
                    end else begin
                        r     <= ONE;
                        state <= S_PIVOT;
                    end
                end
                S_PIVOT: begin
                    if (m[r][k] != '0) begin
                        state <= S_SWAP;
                    end else if (r == nm1) begin
                        zero_res <= 1'b1;
                        state    <= S_FINISH;
                    end else begin
                        r <= r + ONE;
                    end
                end
                S_SWAP: begin
                    for (int cc = 0; cc < N_MAX; cc++) begin
                        m[k][cc] <= m[r][cc];
                        m[r][cc] <= m[k][cc];
                    end
                    sign_neg <= ~sign_neg;
                    i        <= k1;
                    j        <= k1;
                    state    <= S_UPD_MUL;
                end
                S_UPD_MUL: begin
                    state <= S_UPD_DIV;
                end
                S_UPD_DIV: begin
                    if (div_done) begin
                        m[i][j] <= quo;
                        if (j != nm1) begin
                            j     <= j + ONE;
                            state <= S_UPD_MUL;
                        end else if (i != nm1) begin
                            i     <= i + ONE;
                            j     <= k1;
                            state <= S_UPD_MUL;
                        end else begin
                            // M[k+1][k+1] was the first minor of this pass, so it is final here.
                            prev <= m[k][k];
                            k    <= k1;
                            if (k1 == nm1) begin
                                state <= S_FINISH;
                            end else if (m[k1][k1] != '0) begin
                                i     <= k2;
                                j     <= k2;
                                state <= S_UPD_MUL;
                            end else begin
                                r     <= k2;
                                state <= S_PIVOT;
                            end
                        end
                    end
                end
                S_FINISH: begin
                    det_full <= fin_val;
                    ovf      <= (fin_val > SAT_MAX) || (fin_val < SAT_MIN);
                    if (fin_val > SAT_MAX)
                        det <= SAT_MAX[OUT_W-1:0];
                    else if (fin_val < SAT_MIN)
                        det <= SAT_MIN[OUT_W-1:0];
                    else
                        det <= fin_val[OUT_W-1:0];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
